// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the Bayer/Sobel path: arms on start, forwards one frame with X/Y coordinates, muxes filter results.
// proc_* lags in_* by 1 cycle, out_* lags its source by 1 cycle; no backpressure. `CONV_FRAME_STATS_EN adds frame/timeout counters.
module conv_frame_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int PIX_W     = 12,
  parameter int CNT_W     = 11,
  parameter int DRAIN_MAX = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode_sel,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             proc_valid,
  output logic [PIX_W-1:0] proc_pixel,
  output logic [CNT_W-1:0] iX_Cont,
  output logic [CNT_W-1:0] iY_Cont,
  input  logic [PIX_W-1:0] filt_x_pixel,
  input  logic             filt_x_valid,
  input  logic [PIX_W-1:0] filt_y_pixel,
  input  logic             filt_y_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  output logic [1:0]       active_mode,
  output logic             busy,
  output logic             frame_done,
  output logic             err_timeout,
  output logic             err_drop
`ifdef CONV_FRAME_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       timeout_cnt
`endif
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int OC_W = $clog2(NPIX + 1);
  localparam int DC_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_X   = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_Y   = CNT_W'(IMG_H - 1);
  localparam logic [OC_W-1:0]  FULL_CNT = OC_W'(NPIX);
  localparam logic [DC_W-1:0]  LAST_DC  = DC_W'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;
  logic [OC_W-1:0]  out_cnt;
  logic [DC_W-1:0]  drain_cnt;

  logic             in_frame;
  logic             drain_full;
  logic             beat_raw;
  logic [PIX_W-1:0] beat_pix;
  logic             beat_ok;
  logic             lone_valid;
  logic             timeout_hit;
  logic [PIX_W:0]   xy_sum;

  assign busy       = (state != S_IDLE);
  assign in_frame   = (state == S_ACTIVE) || (state == S_DRAIN);
  assign drain_full = (out_cnt == FULL_CNT);
  assign xy_sum     = {1'b0, filt_x_pixel} + {1'b0, filt_y_pixel};
  assign lone_valid = (active_mode == 2'b11) && (filt_x_valid ^ filt_y_valid);

  always_comb begin
    beat_raw = 1'b0;
    beat_pix = '0;
    case (active_mode)
      2'b00: begin
        beat_raw = proc_valid;
        beat_pix = proc_pixel;
      end
      2'b01: begin
        beat_raw = filt_x_valid;
        beat_pix = filt_x_pixel;
      end
      2'b10: begin
        beat_raw = filt_y_valid;
        beat_pix = filt_y_pixel;
      end
      default: begin
        beat_raw = filt_x_valid && filt_y_valid;
        beat_pix = xy_sum[PIX_W] ? {PIX_W{1'b1}} : xy_sum[PIX_W-1:0];
      end
    endcase
  end

  // Once the frame count is met no further beat may leave, so out_valid never lands on frame_done.
  assign beat_ok = beat_raw && ((state == S_ACTIVE) || ((state == S_DRAIN) && !drain_full));

  // A beat arriving on the last drain cycle is taken; the timeout then fires on the next idle cycle.
  assign timeout_hit = (state == S_DRAIN) && !drain_full && !beat_raw && (drain_cnt == LAST_DC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      out_cnt     <= '0;
      drain_cnt   <= '0;
      proc_valid  <= 1'b0;
      proc_pixel  <= '0;
      iX_Cont     <= '0;
      iY_Cont     <= '0;
      out_pixel   <= '0;
      out_valid   <= 1'b0;
      active_mode <= 2'b00;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
`ifdef CONV_FRAME_STATS_EN
      frame_cnt   <= '0;
      timeout_cnt <= '0;
`endif
    end else begin
      proc_valid <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;

      if (beat_ok) begin
        out_valid <= 1'b1;
        out_pixel <= beat_pix;
        if (!drain_full) out_cnt <= out_cnt + 1'b1;
      end

      if (in_frame && lone_valid) err_drop <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_ACTIVE;
            active_mode <= mode_sel;
            x_cnt       <= '0;
            y_cnt       <= '0;
            out_cnt     <= '0;
            drain_cnt   <= '0;
            err_timeout <= 1'b0;
            err_drop    <= 1'b0;
          end else if (in_valid) begin
            err_drop <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (in_valid) begin
            proc_valid <= 1'b1;
            proc_pixel <= in_pixel;
            iX_Cont    <= x_cnt;
            iY_Cont    <= y_cnt;
            if (x_cnt == LAST_X) begin
              x_cnt <= '0;
              if (y_cnt == LAST_Y) begin
                y_cnt     <= '0;
                drain_cnt <= '0;
                state     <= S_DRAIN;
              end else begin
                y_cnt <= y_cnt + 1'b1;
              end
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (in_valid) err_drop <= 1'b1;
          if (drain_full) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
`ifdef CONV_FRAME_STATS_EN
            frame_cnt  <= frame_cnt + 1'b1;
`endif
          end else if (timeout_hit) begin
            state       <= S_DONE;
            frame_done  <= 1'b1;
            err_timeout <= 1'b1;
`ifdef CONV_FRAME_STATS_EN
            frame_cnt   <= frame_cnt + 1'b1;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 1'b1;
`endif
          end else if (drain_cnt != LAST_DC) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          if (in_valid) err_drop <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl on a 4x3 frame: scoreboard queues for proc and out beats, immediate-assert checks.
module tb_conv_frame_ctrl;
  localparam int IMG_W = 4, IMG_H = 3, PIX_W = 12, CNT_W = 11, DRAIN_MAX = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode_sel = 2'b00;
  logic             in_valid = 1'b0;
  logic [PIX_W-1:0] in_pixel = '0;
  logic [PIX_W-1:0] filt_x_pixel = '0;
  logic             filt_x_valid = 1'b0;
  logic [PIX_W-1:0] filt_y_pixel = '0;
  logic             filt_y_valid = 1'b0;
  logic             proc_valid, out_valid, busy, frame_done, err_timeout, err_drop;
  logic [PIX_W-1:0] proc_pixel, out_pixel;
  logic [CNT_W-1:0] iX_Cont, iY_Cont;
  logic [1:0]       active_mode;

  int  vectors = 0, miscompares = 0;
  int  cyc_n = 0, last_out_cyc = 0;
  int  mx = 0, my = 0;
  int  n;
  bit  mon_en = 1'b0;
  logic [PIX_W-1:0]         exp_out[$];
  logic [PIX_W+2*CNT_W-1:0] exp_proc[$];

  conv_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel),
    .in_valid(in_valid), .in_pixel(in_pixel),
    .proc_valid(proc_valid), .proc_pixel(proc_pixel), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .filt_x_pixel(filt_x_pixel), .filt_x_valid(filt_x_valid),
    .filt_y_pixel(filt_y_pixel), .filt_y_valid(filt_y_valid),
    .out_pixel(out_pixel), .out_valid(out_valid), .active_mode(active_mode), .busy(busy),
    .frame_done(frame_done), .err_timeout(err_timeout), .err_drop(err_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {10'b0, proc_valid, proc_pixel, iX_Cont, iY_Cont, out_pixel, out_valid,
            active_mode, busy, frame_done, err_timeout, err_drop};
  endfunction

  // Scoreboard side: every observed beat must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (proc_valid) begin
        if (exp_proc.size() == 0) check("proc_unexpected", proc_valid, 0);
        else check("proc_beat", {proc_pixel, iX_Cont, iY_Cont}, exp_proc.pop_front());
      end
      if (out_valid) begin
        last_out_cyc = cyc_n;
        if (exp_out.size() == 0) check("out_unexpected", out_valid, 0);
        else check("out_beat", out_pixel, exp_out.pop_front());
      end
      if (frame_done) check("done_vs_beat", out_valid, 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0;
    filt_x_valid = 1'b0;
    filt_y_valid = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1;
    mode_sel = m;
    mx = 0;
    my = 0;
    cyc();
    start = 1'b0;
  endtask

  task automatic drive_pix(input logic [PIX_W-1:0] p);
    in_valid = 1'b1;
    in_pixel = p;
    exp_proc.push_back({p, CNT_W'(mx), CNT_W'(my)});
    if (mx == IMG_W - 1) begin
      mx = 0;
      my = my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  task automatic wait_done(input int max, output int edges);
    edges = -1;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (frame_done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic mode00_frame(input string tag);
    do_start(2'b00);
    for (int p = 1; p <= IMG_W * IMG_H; p++) begin
      drive_pix(PIX_W'(p));
      exp_out.push_back(PIX_W'(p));
      cyc();
    end
    clear_inputs();
    wait_done(20, n);
    check({tag, "_done_latency"}, n, 2);
    check({tag, "_done_gap"}, cyc_n - last_out_cyc, 1);
    check({tag, "_out_left"}, exp_out.size(), 0);
    check({tag, "_proc_left"}, exp_proc.size(), 0);
    check({tag, "_errs"}, {err_timeout, err_drop}, 2'b00);
  endtask

  initial begin
    // 1: reset with start/in_valid asserted
    start = 1'b1; in_valid = 1'b1; in_pixel = 12'h5A5; mode_sel = 2'b11;
    #2;
    check("t1_reset_outs", outs(), 64'h0);
    cyc(); cyc();
    check("t1_reset_hold", outs(), 64'h0);
    start = 1'b0; mode_sel = 2'b00;
    rst_n = 1'b1;
    mon_en = 1'b1;
    cyc(); cyc(); cyc();
    check("t1_no_proc", proc_valid, 0);
    check("t1_idle_drop", err_drop, 1);
    check("t1_idle_busy", busy, 0);
    in_valid = 1'b0;
    cyc();

    // 2: pass-through frame, one idle gap in the middle
    do_start(2'b00);
    check("t2_mode", active_mode, 2'b00);
    check("t2_busy", busy, 1);
    check("t2_drop_cleared", err_drop, 0);
    for (int p = 1; p <= IMG_W * IMG_H; p++) begin
      if (p == 6) begin
        in_valid = 1'b0;
        cyc();
      end
      drive_pix(PIX_W'(p));
      exp_out.push_back(PIX_W'(p));
      cyc();
    end
    clear_inputs();
    wait_done(20, n);
    check("t2_done_latency", n, 2);
    check("t2_done_gap", cyc_n - last_out_cyc, 1);
    check("t2_out_left", exp_out.size(), 0);
    check("t2_proc_left", exp_proc.size(), 0);
    check("t2_errs", {err_timeout, err_drop}, 2'b00);
    cyc();
    check("t2_idle_busy", busy, 0);

    // 3: |X|+|Y| saturated, lone X valid
    do_start(2'b11);
    filt_x_valid = 1'b1; filt_x_pixel = 12'hC00; filt_y_valid = 1'b1; filt_y_pixel = 12'h700;
    exp_out.push_back(12'hFFF);
    cyc();
    filt_x_pixel = 12'h100; filt_y_pixel = 12'h200;
    exp_out.push_back(12'h300);
    cyc();
    filt_y_valid = 1'b0; filt_x_pixel = 12'h0AB;
    cyc();
    clear_inputs();
    check("t3_lone_drop", err_drop, 1);
    for (int p = 1; p <= IMG_W * IMG_H; p++) begin
      drive_pix(PIX_W'(p + 'h40));
      if (p <= 10) begin
        int s;
        s = p * 256 + 'h6FF;
        filt_x_valid = 1'b1; filt_x_pixel = PIX_W'(p * 256);
        filt_y_valid = 1'b1; filt_y_pixel = 12'h6FF;
        exp_out.push_back(s > 4095 ? 12'hFFF : PIX_W'(s));
      end else begin
        filt_x_valid = 1'b0;
        filt_y_valid = 1'b0;
      end
      cyc();
    end
    clear_inputs();
    wait_done(20, n);
    check("t3_done_latency", n, 1);
    check("t3_out_left", exp_out.size(), 0);
    check("t3_errs", {err_timeout, err_drop}, 2'b01);

    // 4: Sobel X with mode_sel changed mid-frame
    cyc();
    do_start(2'b01);
    for (int p = 1; p <= IMG_W * IMG_H; p++) begin
      if (p == 5) mode_sel = 2'b10;
      drive_pix(PIX_W'(p));
      filt_x_valid = 1'b1; filt_x_pixel = PIX_W'('h800 + p);
      filt_y_valid = 1'b1; filt_y_pixel = 12'h0AA;
      exp_out.push_back(PIX_W'('h800 + p));
      cyc();
    end
    clear_inputs();
    check("t4_mode_held", active_mode, 2'b01);
    wait_done(20, n);
    check("t4_done_latency", n, 1);
    check("t4_out_left", exp_out.size(), 0);
    check("t4_errs", {err_timeout, err_drop}, 2'b00);

    // 5: drain timeout
    cyc();
    do_start(2'b01);
    for (int p = 1; p <= IMG_W * IMG_H; p++) begin
      drive_pix(PIX_W'(p));
      filt_x_valid = (p <= 3);
      filt_x_pixel = PIX_W'('h300 + p);
      if (p <= 3) exp_out.push_back(PIX_W'('h300 + p));
      cyc();
    end
    clear_inputs();
    wait_done(40, n);
    check("t5_timeout_latency", n, 16);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_err_drop", err_drop, 0);
    check("t5_out_left", exp_out.size(), 0);
    cyc();
    do_start(2'b00);
    check("t5_timeout_cleared", err_timeout, 0);

    // 6: reset mid-frame, then a clean frame
    for (int p = 1; p <= 5; p++) begin
      drive_pix(PIX_W'(p));
      exp_out.push_back(PIX_W'(p));
      cyc();
    end
    clear_inputs();
    #1;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check("t6_reset_outs", outs(), 64'h0);
    exp_out.delete();
    exp_proc.delete();
    cyc(); cyc();
    rst_n = 1'b1;
    mon_en = 1'b1;
    cyc();
    mode00_frame("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
